// File: rtl/uart_transmitter_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1), then an
// optional idle gap of IDLE_GAP bit-times before the next start bit.
module uart_transmitter_fifo #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_GAP     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     data,
  input  logic                           send,
  output logic                           tx,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           busy,
  output logic                           overflow
);

  localparam int CW       = $clog2(DEPTH+1);
  localparam int AW       = $clog2(DEPTH);
  localparam int BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CLKS = IDLE_GAP * CLKS_PER_BIT;
  localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          push, pop, bit_end, gap_end;

  state_t        state;
  logic [BW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    shift;
  logic          par;

  assign bit_end = (clk_cnt == BW'(CLKS_PER_BIT - 1));
  // Never evaluated true when IDLE_GAP==0: the GAP state is unreachable then.
  assign gap_end = (gap_cnt == GW'(GAP_CLKS - 1));
  assign push    = send && !full;
  // Pop happens exactly on the edges where the FSM starts a new frame.
  assign pop     = (count != '0) &&
                   ((state == IDLE) ||
                    (state == STOP && bit_end && IDLE_GAP == 0) ||
                    (state == GAP && gap_end));
  assign busy    = (state != IDLE);

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    cnt_nxt = count;
    if (push && !pop)      cnt_nxt = count + 1'b1;
    else if (!push && pop) cnt_nxt = count - 1'b1;
  end

  // FIFO storage, no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // FIFO pointers, occupancy, registered full and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= cnt_nxt;
      full     <= (cnt_nxt == CW'(DEPTH));
      overflow <= overflow | (send & full);
    end
  end

  // Frame sequencer; tx is registered and set for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else if (pop) begin
      shift   <= mem[rd_ptr];
      par     <= ^mem[rd_ptr];
      tx      <= 1'b0;
      clk_cnt <= '0;
      state   <= START;
    end else begin
      case (state)
        IDLE: tx <= 1'b1;
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= par;
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= 1'b1;
            gap_cnt <= '0;
            state   <= (IDLE_GAP > 0) ? GAP : IDLE;
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        GAP: begin
          tx <= 1'b1;
          if (gap_end) state <= IDLE;
          else         gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// Bench for uart_transmitter_fifo: two configurations (1 clk/bit with a 2-bit
// gap, 4 clks/bit with no gap). A timing model predicts occupancy and when
// each frame starts; a line monitor decodes tx and checks each frame against
// the scoreboard.
module tb_uart_transmitter_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int C  = (gi == 0) ? 1 : 4;
    localparam int G  = (gi == 0) ? 2 : 0;
    localparam int FL = 11 * C;

    logic       rst_n, send, tx, full, busy, overflow;
    logic [7:0] data;
    logic [$clog2(DEPTH+1)-1:0] count;

    exp_t       sb[$];
    logic [7:0] mq[$];
    int         next_free;
    bit         ovf_m;

    uart_transmitter_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(C), .IDLE_GAP(G)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .send(send), .tx(tx),
      .full(full), .count(count), .busy(busy), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL cfg%0d %s: got %0h required %0h (cycle %0d)", gi, nm, act, exp, cyc);
      end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit s, input logic [7:0] d);
      bit   fb, pop;
      exp_t e;
      send = s;
      data = d;
      @(posedge clk);
      #1;
      fb  = (mq.size() == DEPTH);
      pop = (mq.size() > 0) && (cyc >= next_free);
      if (pop) begin
        e.b = mq.pop_front();
        e.t = cyc;
        sb.push_back(e);
        next_free = cyc + (11 + G) * C;
      end
      if (s && !fb) mq.push_back(d);
      if (s && fb)  ovf_m = 1'b1;
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("overflow", overflow, ovf_m);
      chk("busy", busy, cyc < next_free);
    endtask

    task automatic idle(input int nn);
      repeat (nn) step(1'b0, 8'h00);
    endtask

    // Line monitor: a low level outside a frame starts a frame; the full
    // 11-bit waveform is captured and matched against the next expected byte.
    initial begin
      bit               infr;
      int               pos, t0;
      logic [FL-1:0]    smp, want;
      logic [10:0]      fbits;
      exp_t             e;
      infr = 1'b0; pos = 0; t0 = 0; smp = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) infr = 1'b0;
        else begin
          if (!infr && tx === 1'b0) begin
            infr = 1'b1;
            pos  = 0;
            t0   = cyc;
          end
          if (infr) begin
            smp[pos] = tx;
            pos++;
            if (pos == FL) begin
              infr = 1'b0;
              if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cfg%0d unexpected_frame: start at cycle %0d, none required", gi, t0);
              end else begin
                e     = sb.pop_front();
                fbits = {1'b1, ^e.b, e.b, 1'b0};
                for (int k = 0; k < FL; k++) want[k] = fbits[k / C];
                chk("frame_bits", smp, want);
                chk("frame_start", t0, e.t);
              end
            end
          end
        end
      end
    end

    // Stimulus: directed cases, random traffic, then reset in mid-frame.
    initial begin
      rst_n = 1'b0; send = 1'b0; data = 8'h00;
      next_free = 0; ovf_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;

      step(1'b1, 8'hA5); idle((11 + G) * C + 3);
      step(1'b1, 8'h07); idle((11 + G) * C + 3);
      step(1'b1, 8'h00); idle((11 + G) * C + 3);
      for (int k = 1; k <= 6; k++) step(1'b1, 8'(k * 17));
      idle(6 * (11 + G) * C);
      step(1'b1, 8'h3C); step(1'b1, 8'hC3);
      idle(3 * (11 + G) * C);

      repeat (300) step($urandom_range(0, 3) == 0, 8'($urandom));
      for (int k = 0; k < 4000 && (mq.size() != 0 || cyc < next_free); k++) step(1'b0, 8'h00);
      idle(2);

      // Three bytes into an empty idle FIFO; stop on data bit 3 of the first.
      step(1'b1, 8'h96); step(1'b1, 8'h5A); step(1'b1, 8'hF0);
      idle(4 * C - 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx", tx, 1);
      chk("arst_busy", busy, 0);
      chk("arst_count", count, 0);
      chk("arst_overflow", overflow, 0);
      mq.delete(); sb.delete(); next_free = 0; ovf_m = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
        step(1'b0, 8'h00);
        chk("tx_after_rst", tx, 1);
      end
      step(1'b1, 8'h81); idle((11 + G) * C + 3);
      chk("sb_drained", sb.size(), 0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    fork
      wait (done[0] && done[1]);
      #500000;
    join_any
    disable fork;
    if (!(done[0] && done[1])) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: done=%0d%0d required 11", done[1], done[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
